interconn_send_engine: RTL and testbench
========================================

Name: interconn_send_engine

Overview:
Per-MVU transmit engine that drives the sender side of the priority interconnect (send_to/send_en/send_addr/send_word). It takes a block-transfer command and reads consecutive words from the local MVU memory, which has 1-cycle read latency. It streams those words to one or more destination MVUs at consecutive destination addresses. A 2-entry output buffer absorbs interconnect backpressure (send_gnt) so that sustained throughput is 1 word/cycle.

Parameters:
N, 8, number of MVUs (width of one-hot/multi-hot destination mask)
W, 64, data word width
BADDR, 15, memory address width
BLEN, 15, transfer length field width; length encoded as actual_length - 1

Ports:
clk  input  1  clock, rising-edge
clr_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  engine can accept a command
cmd_to  input  N  destination MVU selector bits
cmd_src_addr  input  BADDR  local memory start address
cmd_dst_addr  input  BADDR  remote memory start address
cmd_len  input  BLEN  number of words minus 1
mem_rd_en  output  1  local memory read strobe
mem_rd_addr  output  BADDR  local memory read address
mem_rd_word  input  W  read data, valid the cycle after mem_rd_en
send_to  output  N  interconnect destination selector
send_en  output  1  interconnect word valid
send_addr  output  BADDR  remote write address
send_word  output  W  data word
send_gnt  input  1  interconnect accepts the current word
busy  output  1  transfer in progress
done  output  1  1-cycle pulse after the last word is accepted

Behaviour:
- Reset (clr_n=0, async): state IDLE; cmd_ready=1; busy=0; done=0; mem_rd_en=0; send_en=0; send_to, send_addr, send_word, mem_rd_addr = 0; buffer emptied; in-flight read discarded.
- FSM states:
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid && cmd_ready. On acceptance, latch cmd_to, src, dst and len, and clear the issue and accept counters.
  - If the accepted cmd_to == 0, go to DONE (no reads, no sends). Otherwise go to RUN.
  - RUN: busy=1, cmd_ready=0.
  - DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 while in DONE.
- Read issue in RUN:
  - A read is issued in cycle c when issued_count ≤ len and (buffer_occupancy + reads_in_flight − beat_accepted_this_cycle) < 2. This never overflows the 2-entry buffer.
  - mem_rd_addr = src + issued_count, modulo 2^BADDR.
  - The first read is issued in the cycle after acceptance.
- Buffer: mem_rd_word is written into the buffer at the end of the cycle after mem_rd_en. The buffer head drives send_word with registered outputs.
- Send rules:
  - send_en=1 whenever the buffer is non-empty.
  - send_to = latched cmd_to for the whole command.
  - send_addr = dst + accepted_count, modulo 2^BADDR.
  - A beat is accepted on the rising edge where send_en && send_gnt. The buffer pops and accepted_count increments.
  - While send_en=1 && send_gnt=0, send_to, send_addr and send_word hold stable.
  - When send_en=0, send_addr and send_word hold their last values.
- Latency with send_gnt held at 1:
  - Acceptance in cycle 0, mem_rd_en in cycle 1.
  - Word k appears on send_* in cycle 3+k.
  - The last word appears in cycle 3+len. done is high in cycle 4+len. cmd_ready returns high in cycle 5+len.
- Completion: when accepted_count reaches len+1, go to DONE. mem_rd_en is never asserted beyond len+1 reads.
- Backpressure: send_gnt may drop at any cycle. Read issue stalls per the credit rule. There is no loss or duplication of words, and order is preserved.
- Max length: cmd_len = 2^BLEN − 1. Counters are BLEN+1 bits so they do not alias.
- Address wrap: an address at 2^BADDR − 1 wraps to 0 on both the read side and the send side.
- cmd_valid is ignored outside IDLE. Command fields are sampled only on acceptance.
- Reset mid-transfer: immediate return to reset state. No done pulse. The remaining words are never sent.

Test Plan:
- Single word: cmd_to=8'b0000_0100, src=5, dst=7, len=0, gnt=1 → mem_rd_en at cycle 1 with addr 5; send_en in cycle 3 only, with send_addr=7, send_word=mem[5]; done in cycle 4.
- Burst of 8 with gnt=1: len=7, src=0x10, dst=0x20 → 8 consecutive send_en cycles (3..10); send_addr 0x20..0x27; words mem[0x10..0x17] in order; exactly 8 reads; done in cycle 11.
- Backpressure: len=5, gnt pattern 1,0,0,1,0,1,1,1,... → each word is held stable while gnt=0; exactly 6 accepted beats in order; buffer never exceeds 2; mem_rd_en pauses while the buffer is full.
- Wrap and multicast: src=0x7FFE, dst=0x7FFF, len=2, cmd_to=8'hFF → reads at 0x7FFE, 0x7FFF, 0x0000; send_addr 0x7FFF, 0x0000, 0x0001; send_to=8'hFF on every beat.
- Null destination: cmd_to=0, len=3 → no mem_rd_en, no send_en; done in cycle 1; cmd_ready high again in cycle 2.
- Reset mid-burst: len=15, gnt=1, clr_n pulled low asynchronously at cycle 8 → send_en, mem_rd_en and busy drop immediately with no done pulse. After release, a new len=0 command completes normally with a fresh send_addr=dst.

Source files
------------

// File: rtl/interconn_send_engine.sv
// interconn_send_engine: per-MVU transmit engine. It accepts a block-transfer
// command, reads consecutive words from local memory (1-cycle read latency)
// and streams them to the selected destination MVUs at consecutive remote
// addresses. A 2-entry buffer soaks up send_gnt backpressure so that a
// stream runs at one word per cycle when it is not stalled.
module interconn_send_engine #(
    parameter int N     = 8,
    parameter int W     = 64,
    parameter int BADDR = 15,
    parameter int BLEN  = 15
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_to,
    input  logic [BADDR-1:0] cmd_src_addr,
    input  logic [BADDR-1:0] cmd_dst_addr,
    input  logic [BLEN-1:0]  cmd_len,
    output logic             mem_rd_en,
    output logic [BADDR-1:0] mem_rd_addr,
    input  logic [W-1:0]     mem_rd_word,
    output logic [N-1:0]     send_to,
    output logic             send_en,
    output logic [BADDR-1:0] send_addr,
    output logic [W-1:0]     send_word,
    input  logic             send_gnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched command fields
    logic [N-1:0]     to_q;
    logic [BADDR-1:0] src_q;
    logic [BADDR-1:0] dst_q;
    logic [BLEN-1:0]  len_q;

    // Counters are one bit wider than the length field so a maximum-length
    // transfer (len+1 = 2^BLEN words) can still be counted without aliasing.
    logic [BLEN:0]    issued_q;
    logic [BLEN:0]    accepted_q;

    // Read in flight: data lands on mem_rd_word during the following cycle
    logic             pending_q;

    // Two-entry output buffer: head drives send_word, tail is the overflow slot
    logic [1:0]       occ_q;
    logic [W-1:0]     head_q;
    logic [W-1:0]     tail_q;
    logic [BADDR-1:0] addr_q;

    logic             cmd_fire;
    logic             beat;
    logic             last_beat;
    logic [2:0]       outstanding;
    logic             credit_ok;

    assign cmd_fire    = (state_q == IDLE) && cmd_valid;
    assign send_en     = (occ_q != 2'd0);
    assign beat        = send_en && send_gnt;
    assign last_beat   = beat && (accepted_q == {1'b0, len_q});

    // A word accepted this cycle frees a slot, so one more read may issue
    assign outstanding = {1'b0, occ_q} + {2'b00, pending_q};
    assign credit_ok   = outstanding < (beat ? 3'd3 : 3'd2);

    assign mem_rd_en   = (state_q == RUN) && (issued_q <= {1'b0, len_q}) && credit_ok;
    assign mem_rd_addr = src_q + BADDR'(issued_q);

    assign send_to     = to_q;
    assign send_addr   = addr_q;
    assign send_word   = head_q;

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = (cmd_to == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch, read/accept counters and the outgoing remote address;
    // the address is not advanced past the final beat so it holds afterwards
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            to_q       <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            addr_q     <= '0;
            pending_q  <= 1'b0;
        end else begin
            pending_q <= mem_rd_en;
            if (cmd_fire) begin
                to_q       <= cmd_to;
                src_q      <= cmd_src_addr;
                dst_q      <= cmd_dst_addr;
                len_q      <= cmd_len;
                issued_q   <= '0;
                accepted_q <= '0;
                addr_q     <= cmd_dst_addr;
            end else begin
                if (mem_rd_en) begin
                    issued_q <= issued_q + 1'b1;
                end
                if (beat) begin
                    accepted_q <= accepted_q + 1'b1;
                    if (!last_beat) begin
                        addr_q <= dst_q + BADDR'(accepted_q + 1'b1);
                    end
                end
            end
        end
    end

    // Output buffer: push returning read data, pop on an accepted beat;
    // the head keeps its last value when the buffer drains
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (pending_q) begin
                        head_q <= mem_rd_word;
                        occ_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pending_q && beat) begin
                        head_q <= mem_rd_word;
                    end else if (pending_q) begin
                        tail_q <= mem_rd_word;
                        occ_q  <= 2'd2;
                    end else if (beat) begin
                        occ_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (beat) begin
                        head_q <= tail_q;
                        if (pending_q) begin
                            tail_q <= mem_rd_word;
                        end else begin
                            occ_q <= 2'd1;
                        end
                    end
                end
                default: begin
                    occ_q <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interconn_send_engine.sv
// tb_interconn_send_engine: directed testbench for interconn_send_engine with
// a behavioural 1-cycle-latency memory and a per-cycle activity recorder.
module tb_interconn_send_engine;

    logic        clk;
    logic        clr_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_to;
    logic [14:0] cmd_src_addr;
    logic [14:0] cmd_dst_addr;
    logic [14:0] cmd_len;
    logic        mem_rd_en;
    logic [14:0] mem_rd_addr;
    logic [63:0] mem_rd_word;
    logic [7:0]  send_to;
    logic        send_en;
    logic [14:0] send_addr;
    logic [63:0] send_word;
    logic        send_gnt;
    logic        busy;
    logic        done;

    int checkCount = 0;
    int passCount  = 0;

    // Activity recorded during one command
    int          readAddr[$];
    int          readCyc[$];
    int          beatAddr[$];
    logic [63:0] beatWord[$];
    int          beatTo[$];
    int          beatCyc[$];
    int          doneCount;
    int          doneCycle;
    int          readyCycle;
    int          maxOutstanding;

    interconn_send_engine #(.N(8), .W(64), .BADDR(15), .BLEN(15)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_to       (cmd_to),
        .cmd_src_addr (cmd_src_addr),
        .cmd_dst_addr (cmd_dst_addr),
        .cmd_len      (cmd_len),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_word  (mem_rd_word),
        .send_to      (send_to),
        .send_en      (send_en),
        .send_addr    (send_addr),
        .send_word    (send_word),
        .send_gnt     (send_gnt),
        .busy         (busy),
        .done         (done)
    );

    // Clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address
    function automatic logic [63:0] memWord(input logic [14:0] a);
        return {16'hC0DE, 1'b0, a, 32'h5A5A_0000 ^ {17'd0, a}};
    endfunction

    // Local memory model with one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_word <= memWord(mem_rd_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Runs one command from cycle 0 (acceptance) until cmd_ready returns,
    // recording reads, accepted beats and the done pulse. gntPat bit c gives
    // send_gnt in cycle c; cycles past 31 are granted. With holdValid the
    // command request stays asserted with unrelated fields until done.
    task automatic applyStimulus(input logic [7:0] to, input logic [14:0] src,
                                 input logic [14:0] dst, input logic [14:0] len,
                                 input logic [31:0] gntPat, input bit holdValid,
                                 input int budget);
        bit          prevStall;
        logic [14:0] prevAddr;
        logic [63:0] prevWord;
        logic [7:0]  prevTo;
        int          issued;
        int          accepted;
        readAddr.delete(); readCyc.delete(); beatAddr.delete();
        beatWord.delete(); beatTo.delete(); beatCyc.delete();
        doneCount = 0; doneCycle = -1; readyCycle = -1; maxOutstanding = 0;
        issued = 0; accepted = 0; prevStall = 0;
        prevAddr = '0; prevWord = '0; prevTo = '0;
        cmd_valid    = 1'b1;
        cmd_to       = to;
        cmd_src_addr = src;
        cmd_dst_addr = dst;
        cmd_len      = len;
        send_gnt     = gntPat[0];
        #1;
        checkOutput("cmd_ready_at_accept", cmd_ready, 1);
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (holdValid && doneCount == 0) begin
                cmd_valid    = 1'b1;
                cmd_to       = 8'h01;
                cmd_src_addr = 15'h1234;
                cmd_dst_addr = 15'h0555;
                cmd_len      = 15'd3;
            end else begin
                cmd_valid = 1'b0;
            end
            send_gnt = (c < 32) ? gntPat[c] : 1'b1;
            #1;
            if (prevStall) begin
                checkOutput($sformatf("hold_en_c%0d", c), send_en, 1);
                checkOutput($sformatf("hold_addr_c%0d", c), send_addr, prevAddr);
                checkOutput($sformatf("hold_word_c%0d", c), send_word, prevWord);
                checkOutput($sformatf("hold_to_c%0d", c), send_to, prevTo);
            end
            prevStall = send_en && !send_gnt;
            prevAddr  = send_addr;
            prevWord  = send_word;
            prevTo    = send_to;
            if (mem_rd_en) begin
                readAddr.push_back(int'(mem_rd_addr));
                readCyc.push_back(c);
                issued++;
            end
            if (send_en && send_gnt) begin
                beatAddr.push_back(int'(send_addr));
                beatWord.push_back(send_word);
                beatTo.push_back(int'(send_to));
                beatCyc.push_back(c);
                accepted++;
            end
            if (issued - accepted > maxOutstanding) maxOutstanding = issued - accepted;
            if (done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = c;
                cmd_valid = 1'b0;
            end
            if (cmd_ready) begin
                readyCycle = c;
                break;
            end
        end
        cmd_valid = 1'b0;
        send_gnt  = 1'b1;
        if (readyCycle < 0) begin
            checkOutput("timeout_waiting_cmd_ready", 0, 1);
        end
    endtask

    // Compares the recorded run with the expected transfer; with fullRate the
    // read and beat cycles must follow the back-to-back schedule
    task automatic verifyRun(input string tag, input logic [7:0] to, input logic [14:0] src,
                             input logic [14:0] dst, input int words, input int expDone,
                             input bit fullRate);
        logic [14:0] ea;
        checkOutput({tag, "_reads"}, readAddr.size(), words);
        checkOutput({tag, "_beats"}, beatAddr.size(), words);
        checkOutput({tag, "_done_cycle"}, doneCycle, expDone);
        checkOutput({tag, "_done_pulses"}, doneCount, 1);
        checkOutput({tag, "_ready_cycle"}, readyCycle, expDone + 1);
        checkOutput({tag, "_outstanding_le2"}, (maxOutstanding <= 2), 1);
        for (int i = 0; i < words && i < readAddr.size(); i++) begin
            ea = src + 15'(i);
            checkOutput($sformatf("%s_rd_addr%0d", tag, i), readAddr[i], ea);
            if (fullRate) checkOutput($sformatf("%s_rd_cyc%0d", tag, i), readCyc[i], 1 + i);
        end
        for (int i = 0; i < words && i < beatAddr.size(); i++) begin
            ea = dst + 15'(i);
            checkOutput($sformatf("%s_send_addr%0d", tag, i), beatAddr[i], ea);
            ea = src + 15'(i);
            checkOutput($sformatf("%s_send_word%0d", tag, i), beatWord[i], memWord(ea));
            checkOutput($sformatf("%s_send_to%0d", tag, i), beatTo[i], to);
            if (fullRate) checkOutput($sformatf("%s_send_cyc%0d", tag, i), beatCyc[i], 3 + i);
        end
    endtask

    int bpCycles[6] = '{3, 6, 8, 9, 10, 11};

    initial begin
        clr_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_to       = '0;
        cmd_src_addr = '0;
        cmd_dst_addr = '0;
        cmd_len      = '0;
        send_gnt     = 1'b1;
        mem_rd_word  = '0;
        #2;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_send_en", send_en, 0);
        checkOutput("rst_mem_rd_en", mem_rd_en, 0);
        checkOutput("rst_send_to", send_to, 0);
        checkOutput("rst_send_addr", send_addr, 0);
        checkOutput("rst_send_word", send_word, 0);
        checkOutput("rst_mem_rd_addr", mem_rd_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;

        $display("[TB] single word");
        applyStimulus(8'b0000_0100, 15'd5, 15'd7, 15'd0, 32'hFFFF_FFFF, 0, 50);
        verifyRun("single", 8'b0000_0100, 15'd5, 15'd7, 1, 4, 1);

        $display("[TB] burst of 8 with cmd_valid held during the transfer");
        applyStimulus(8'h02, 15'h0010, 15'h0020, 15'd7, 32'hFFFF_FFFF, 1, 60);
        verifyRun("burst", 8'h02, 15'h0010, 15'h0020, 8, 11, 1);

        $display("[TB] backpressure");
        applyStimulus(8'h08, 15'h0100, 15'h0300, 15'd5, 32'hFFFF_FF4F, 0, 80);
        verifyRun("bp", 8'h08, 15'h0100, 15'h0300, 6, 12, 0);
        for (int i = 0; i < 6 && i < beatCyc.size(); i++) begin
            checkOutput($sformatf("bp_beat_cyc%0d", i), beatCyc[i], bpCycles[i]);
        end

        $display("[TB] wrap and multicast");
        applyStimulus(8'hFF, 15'h7FFE, 15'h7FFF, 15'd2, 32'hFFFF_FFFF, 0, 50);
        verifyRun("wrap", 8'hFF, 15'h7FFE, 15'h7FFF, 3, 6, 1);

        $display("[TB] null destination");
        applyStimulus(8'h00, 15'd9, 15'd11, 15'd3, 32'hFFFF_FFFF, 0, 20);
        checkOutput("null_reads", readAddr.size(), 0);
        checkOutput("null_beats", beatAddr.size(), 0);
        checkOutput("null_done_cycle", doneCycle, 1);
        checkOutput("null_ready_cycle", readyCycle, 2);

        $display("[TB] reset mid-burst");
        cmd_valid    = 1'b1;
        cmd_to       = 8'h10;
        cmd_src_addr = 15'h0100;
        cmd_dst_addr = 15'h0200;
        cmd_len      = 15'd15;
        send_gnt     = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
        #1;
        checkOutput("midrst_sending", send_en, 1);
        checkOutput("midrst_busy_before", busy, 1);
        clr_n = 1'b0;
        #1;
        checkOutput("midrst_send_en", send_en, 0);
        checkOutput("midrst_mem_rd_en", mem_rd_en, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("midrst_no_done%0d", i), done, 0);
        end
        clr_n = 1'b1;
        applyStimulus(8'h02, 15'd3, 15'h0040, 15'd0, 32'hFFFF_FFFF, 0, 50);
        verifyRun("after_rst", 8'h02, 15'd3, 15'h0040, 1, 4, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
